// File: rtl/j202_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : j202_wb_arbiter
// Purpose  : Round-robin two-master Wishbone classic arbiter with bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
module j202_wb_arbiter #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    output logic [3:0]    s_sel_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    output logic [1:0]    grant_o,
    output logic          timeout_o
);

    // A disabled timeout still needs a legal 1-bit counter.
    localparam int          TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic        TO_EN  = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic          w_req0, w_req1, w_sel1, w_busy, w_resp, w_timeout;
    logic          w_cyc, w_stb, w_we, w_ack, w_err;
    logic [AW-1:0] w_adr;
    logic [31:0]   w_dat;
    logic [3:0]    w_sel;

    always_comb begin
        w_req0 = m0_cyc_i & m0_stb_i;
        w_req1 = m1_cyc_i & m1_stb_i;
        w_sel1 = (state_q == BUS1);
        w_busy = (state_q != IDLE);
        w_cyc  = w_sel1 ? m1_cyc_i : m0_cyc_i;
        w_stb  = w_sel1 ? m1_stb_i : m0_stb_i;
        w_we   = w_sel1 ? m1_we_i  : m0_we_i;
        w_adr  = w_sel1 ? m1_adr_i : m0_adr_i;
        w_dat  = w_sel1 ? m1_dat_i : m0_dat_i;
        w_sel  = w_sel1 ? m1_sel_i : m0_sel_i;
        w_resp = s_ack_i | s_err_i;
        // A slave response or a master abort in the deadline cycle pre-empts the timeout.
        w_timeout = w_busy & TO_EN & w_cyc & ~w_resp & (cnt_q == TO_VAL);

        s_cyc_o = w_busy & w_cyc & ~w_timeout;
        s_stb_o = w_busy & w_stb & ~w_timeout;
        s_we_o  = w_busy & w_we;
        s_adr_o = w_busy ? w_adr : '0;
        s_dat_o = w_busy ? w_dat : '0;
        s_sel_o = w_busy ? w_sel : '0;

        // Error dominates ack when the slave raises both.
        w_ack = s_ack_i & ~s_err_i;
        w_err = s_err_i | w_timeout;

        m0_dat_o = (state_q == BUS0) ? s_dat_i : '0;
        m0_ack_o = (state_q == BUS0) & w_ack;
        m0_err_o = (state_q == BUS0) & w_err;
        m1_dat_o = w_sel1 ? s_dat_i : '0;
        m1_ack_o = w_sel1 & w_ack;
        m1_err_o = w_sel1 & w_err;

        grant_o   = {w_sel1, (state_q == BUS0)};
        timeout_o = w_timeout;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (w_req0 && (!w_req1 || last_q)) begin
                    state_d = BUS0;
                    last_d  = 1'b0;
                end else if (w_req1) begin
                    state_d = BUS1;
                    last_d  = 1'b1;
                end
            end
            BUS0, BUS1: begin
                if (!w_cyc || w_timeout) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (w_resp) begin
                    cnt_d = '0;
                end else if (w_stb) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_j202_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_j202_wb_arbiter
// Purpose  : Directed self-checking bench for the two-master Wishbone arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_j202_wb_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [31:0]   m0_wdat, m1_wdat;
    logic [3:0]    m0_sel, m1_sel;
    logic [31:0]   m0_rdat, m1_rdat;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [31:0]   s_wdat, s_rdat;
    logic [3:0]    s_sel;
    logic          s_ack, s_err;
    logic [1:0]    grant;
    logic          tmo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    j202_wb_arbiter #(.AW(AW), .TIMEOUT(4)) dut (
        .wb_clk_i (clk),     .wb_rst_ni(rst_n),
        .m0_cyc_i (m0_cyc),  .m0_stb_i (m0_stb),  .m0_we_i (m0_we),
        .m0_adr_i (m0_adr),  .m0_dat_i (m0_wdat), .m0_sel_i(m0_sel),
        .m0_dat_o (m0_rdat), .m0_ack_o (m0_ack),  .m0_err_o(m0_err),
        .m1_cyc_i (m1_cyc),  .m1_stb_i (m1_stb),  .m1_we_i (m1_we),
        .m1_adr_i (m1_adr),  .m1_dat_i (m1_wdat), .m1_sel_i(m1_sel),
        .m1_dat_o (m1_rdat), .m1_ack_o (m1_ack),  .m1_err_o(m1_err),
        .s_cyc_o  (s_cyc),   .s_stb_o  (s_stb),   .s_we_o  (s_we),
        .s_adr_o  (s_adr),   .s_dat_o  (s_wdat),  .s_sel_o (s_sel),
        .s_dat_i  (s_rdat),  .s_ack_i  (s_ack),   .s_err_i (s_err),
        .grant_o  (grant),   .timeout_o(tmo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks follow 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0; m1_sel = '0;
        s_rdat = '0; s_ack = 0; s_err = 0;
        repeat (3) tick();
        check("rst_grant", grant, 2'b00);
        check("rst_scyc", {s_cyc, s_stb, s_we}, 3'b000);
        check("rst_resp", {m0_ack, m0_err, m1_ack, m1_err, tmo}, 5'b0);
        rst_n = 1'b1;

        // Single read by m0 with two wait states
        tick();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3000_0000; m0_sel = 4'hF;
        settle();
        check("t1_idle_grant", grant, 2'b00);
        check("t1_idle_stb", s_stb, 1'b0);
        tick();
        check("t1_grant", grant, 2'b01);
        check("t1_stb", {s_cyc, s_stb}, 2'b11);
        check("t1_adr", s_adr, 32'h3000_0000);
        check("t1_noack", m0_ack, 1'b0);
        tick();
        check("t1_wait2", s_stb, 1'b1);
        tick();
        s_ack = 1; s_rdat = 32'hDEAD_BEEF;
        settle();
        check("t1_ack", m0_ack, 1'b1);
        check("t1_dat", m0_rdat, 32'hDEAD_BEEF);
        check("t1_m1_dat", {m1_ack, m1_rdat}, 33'h0);
        tick();
        m0_cyc = 0; m0_stb = 0; s_ack = 0; s_rdat = '0;
        settle();
        check("t1_drop_scyc", s_cyc, 1'b0);
        tick();
        check("t1_idle_after", grant, 2'b00);

        // Tie after reset: m0 first, then m1 not preempted by m0
        do_reset();
        tick();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
        tick();
        check("t2_first", grant, 2'b01);
        s_ack = 1;
        settle();
        check("t2_m0ack", {m0_ack, m1_ack}, 2'b10);
        tick();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        tick();
        check("t2_idle", grant, 2'b00);
        m0_cyc = 1; m0_stb = 1;
        tick();
        check("t2_second", grant, 2'b10);
        check("t2_adr", s_adr, 32'h200);
        s_ack = 1;
        settle();
        check("t2_m1ack", {m0_ack, m1_ack}, 2'b01);
        tick();
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        tick();
        tick();
        check("t2_m0_again", grant, 2'b01);
        m0_cyc = 0; m0_stb = 0;
        tick();

        // Round robin: both masters always requesting single writes
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h10; m0_wdat = 32'hA0A0_0000;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h20; m1_wdat = 32'hB1B1_0000;
        for (int i = 0; i < 16; i++) begin
            logic [1:0] exp_g;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check("rr_grant", grant, exp_g);
            check("rr_wdat", s_wdat, (i % 2 == 0) ? 32'hA0A0_0000 : 32'hB1B1_0000);
            s_ack = 1;
            settle();
            if (i % 2 == 0) check("rr_acks0", {m0_ack, m1_ack, m1_err}, 3'b100);
            else            check("rr_acks1", {m1_ack, m0_ack, m0_err}, 3'b100);
            tick();
            s_ack = 0;
            if (i % 2 == 0) begin m0_cyc = 0; m0_stb = 0; end
            else            begin m1_cyc = 0; m1_stb = 0; end
            tick();
            check("rr_idle", grant, 2'b00);
            m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        end
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        // Timeout: m1 write never acknowledged
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h44;
        tick();
        check("to_first_stb", {grant, s_stb, tmo}, 4'b1010);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("to_pending", {tmo, m1_err, s_cyc}, 3'b001);
        end
        tick();
        check("to_fire", {tmo, m1_err}, 2'b11);
        check("to_scyc", {s_cyc, s_stb}, 2'b00);
        check("to_grant", grant, 2'b10);
        tick();
        m1_cyc = 0; m1_stb = 0;
        check("to_after", {grant, tmo, m1_err}, 4'b0000);
        tick();

        // Ack in the deadline cycle wins over the timeout
        m1_cyc = 1; m1_stb = 1;
        tick();
        repeat (4) tick();
        s_ack = 1;
        settle();
        check("to_ackwins", {m1_ack, m1_err, tmo, s_cyc}, 4'b1001);
        tick();
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        tick();

        // Ack and err together: err passes, ack masked
        m1_cyc = 1; m1_stb = 1;
        tick();
        s_ack = 1; s_err = 1;
        settle();
        check("ackerr", {m1_ack, m1_err, tmo}, 3'b010);
        tick();
        m1_cyc = 0; m1_stb = 0; s_ack = 0; s_err = 0;
        tick();

        // Burst hold with m1 waiting, then abort mid-wait
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h3000_0010;
        m1_cyc = 1; m1_stb = 1;
        tick();
        for (int b = 0; b < 3; b++) begin
            s_ack = 1; s_rdat = 32'h1111_0000 + b;
            settle();
            check("burst_grant", grant, 2'b01);
            check("burst_ack", {m0_ack, m1_ack}, 2'b10);
            check("burst_dat", m0_rdat, 32'h1111_0000 + b);
            tick();
        end
        s_ack = 0; s_rdat = '0;
        tick();
        check("burst_hold", grant, 2'b01);
        m0_cyc = 0; m0_stb = 0;
        settle();
        check("abort_scyc", s_cyc, 1'b0);
        tick();
        check("abort_idle", grant, 2'b00);

        // Async reset during BUS1
        tick();
        check("ar_bus1", {grant, s_cyc}, 3'b101);
        s_ack = 1; s_rdat = 32'h5555_AAAA;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_grant", grant, 2'b00);
        check("ar_slave", {s_cyc, s_stb, s_we, s_adr}, 35'h0);
        check("ar_resp", {m1_ack, m1_err, m1_rdat, m0_ack, tmo}, 36'h0);
        s_ack = 0; s_rdat = '0;
        m0_cyc = 1; m0_stb = 1;
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_last", grant, 2'b01);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
